// File: rtl/mips_pkg.sv
// Shared register-file constants and the writeback queue entry layout.
package mips_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  // One queued long-latency result: destination, value, and its WAW kill bit.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
    logic              kill;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Long-latency result queue. It holds storage, pointers, count and per-entry
// kill bits. A parallel rd-compare over the live entries serves both the WAW
// squash and the two busy lookups.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  AW    = REG_AW,
  parameter int  DW    = DATA_W,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [AW-1:0] push_rd_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [AW-1:0] head_rd_o,
  output logic [DW-1:0] head_data_o,
  output logic          head_kill_o,
  input  logic          squash_i,
  input  logic [AW-1:0] squash_rd_i,
  input  logic [AW-1:0] q_rs_i,
  input  logic [AW-1:0] q_rt_i,
  output logic          busy_rs_o,
  output logic          busy_rt_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [AW-1:0]    rd_mem   [DEPTH];
  logic [DW-1:0]    data_mem [DEPTH];
  logic [DEPTH-1:0] kill_q, kill_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic [PW-1:0]    off [DEPTH];
  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] match_sq, match_rs, match_rt;

  // Live-slot mask from distance to the head, plus the parallel rd compares.
  always_comb begin
    live     = '0;
    match_sq = '0;
    match_rs = '0;
    match_rt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off[i]      = PW'(i) - rd_ptr_q;
      live[i]     = {1'b0, off[i]} < count_q;
      match_sq[i] = live[i] && (rd_mem[i] == squash_rd_i);
      match_rs[i] = live[i] && !kill_q[i] && (rd_mem[i] == q_rs_i);
      match_rt[i] = live[i] && !kill_q[i] && (rd_mem[i] == q_rt_i);
    end
  end

  // A popping entry is still live here, a pushing one is not yet.
  assign busy_rs_o = (q_rs_i != AW'(REG_ZERO)) && (|match_rs);
  assign busy_rt_o = (q_rt_i != AW'(REG_ZERO)) && (|match_rt);

  assign head_rd_o   = rd_mem[rd_ptr_q];
  assign head_data_o = data_mem[rd_ptr_q];
  assign head_kill_o = kill_q[rd_ptr_q];

  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  // Next pointers/count/kill; the pushed slot's kill clear overrides the squash.
  always_comb begin
    kill_d   = kill_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (squash_i) begin
      kill_d = kill_q | match_sq;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_i) begin
      kill_d[wr_ptr_q] = 1'b0;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end

  // Control state: pointers, count and kill bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kill_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      kill_q   <= kill_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload storage; validity comes from the count so no reset needed.
  always_ff @(posedge clk) begin
    if (push_i) begin
      rd_mem[wr_ptr_q]   <= push_rd_i;
      data_mem[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port producer. The in-order pipeline result always wins
// the port; queued long-latency results drain in bubbles. Pipeline writes kill
// older queued writes to the same register so the younger value survives.
module wb_arbiter
  import mips_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  AW    = REG_AW,
  parameter int  DW    = DATA_W,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p_valid,
  input  logic [AW-1:0] p_rd,
  input  logic [DW-1:0] p_data,
  input  logic          m_valid,
  output logic          m_ready,
  input  logic [AW-1:0] m_rd,
  input  logic [DW-1:0] m_data,
  output logic          regwrite,
  output logic [AW-1:0] rd,
  output logic [DW-1:0] writedata,
  input  logic [AW-1:0] q_rs,
  input  logic [AW-1:0] q_rt,
  output logic          busy_rs,
  output logic          busy_rt,
  output logic [CW-1:0] fifo_count
);

  logic          push, pop, squash;
  logic          full, empty;
  logic [AW-1:0] head_rd;
  logic [DW-1:0] head_data;
  logic          head_kill;

  logic          armed_q;
  logic          regwrite_q, regwrite_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [DW-1:0] wdata_q, wdata_d;

  // Ready stays low through reset and comes up one clock after release.
  assign m_ready = armed_q && !full;
  assign push    = m_valid && m_ready;
  assign pop     = !p_valid && !empty;
  assign squash  = p_valid && (p_rd != AW'(REG_ZERO));

  wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_rd_i   (m_rd),
    .push_data_i (m_data),
    .pop_i       (pop),
    .head_rd_o   (head_rd),
    .head_data_o (head_data),
    .head_kill_o (head_kill),
    .squash_i    (squash),
    .squash_rd_i (p_rd),
    .q_rs_i      (q_rs),
    .q_rt_i      (q_rt),
    .busy_rs_o   (busy_rs),
    .busy_rt_o   (busy_rt),
    .count_o     (fifo_count),
    .full_o      (full),
    .empty_o     (empty)
  );

  // Write-port selection: pipeline first, then queue head, else idle hold.
  always_comb begin
    regwrite_d = 1'b0;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    if (p_valid) begin
      regwrite_d = (p_rd != AW'(REG_ZERO));
      rd_d       = p_rd;
      wdata_d    = p_data;
    end else if (!empty) begin
      regwrite_d = (head_rd != AW'(REG_ZERO)) && !head_kill;
      rd_d       = head_rd;
      wdata_d    = head_data;
    end
  end

  // Output register and the post-reset ready enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
    end else begin
      armed_q    <= 1'b1;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
    end
  end

  assign regwrite  = regwrite_q;
  assign rd        = rd_q;
  assign writedata = wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model, per-cycle compare on the
// falling edge, directed scenarios with literal expectations, random traffic.
module tb_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p_valid = 1'b0;
  logic [AW-1:0] p_rd = '0;
  logic [DW-1:0] p_data = '0;
  logic          m_valid = 1'b0;
  logic [AW-1:0] m_rd = '0;
  logic [DW-1:0] m_data = '0;
  logic [AW-1:0] q_rs = '0;
  logic [AW-1:0] q_rt = '0;
  logic          m_ready;
  logic          regwrite;
  logic [AW-1:0] rd;
  logic [DW-1:0] writedata;
  logic          busy_rs;
  logic          busy_rt;
  logic [2:0]    fifo_count;

  wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_valid    (p_valid),
    .p_rd       (p_rd),
    .p_data     (p_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_rd       (m_rd),
    .m_data     (m_data),
    .regwrite   (regwrite),
    .rd         (rd),
    .writedata  (writedata),
    .q_rs       (q_rs),
    .q_rt       (q_rt),
    .busy_rs    (busy_rs),
    .busy_rt    (busy_rt),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    bit            kill;
  } ent_t;

  ent_t          mq[$];
  bit            started = 1'b0;
  bit            exp_we  = 1'b0;
  logic [AW-1:0] exp_rd  = '0;
  logic [DW-1:0] exp_wd  = '0;
  logic [DW-1:0] rf [32];

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit busy_of(input logic [AW-1:0] q);
    if (q == 0) return 1'b0;
    foreach (mq[i]) if (!mq[i].kill && mq[i].rd == q) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: a queue of pending results and the register-file image.
  always @(posedge clk or posedge rst) begin : model
    bit   acc;
    ent_t e;
    if (rst) begin
      mq.delete();
      exp_we  = 1'b0;
      exp_rd  = '0;
      exp_wd  = '0;
      started = 1'b0;
    end else begin
      acc = m_valid && started && (mq.size() < DEPTH);
      if (p_valid) begin
        exp_we = (p_rd != 0);
        exp_rd = p_rd;
        exp_wd = p_data;
        if (p_rd != 0) foreach (mq[i]) if (mq[i].rd == p_rd) mq[i].kill = 1'b1;
      end else if (mq.size() != 0) begin
        e      = mq.pop_front();
        exp_we = (e.rd != 0) && !e.kill;
        exp_rd = e.rd;
        exp_wd = e.data;
      end else begin
        exp_we = 1'b0;
      end
      if (exp_we) rf[exp_rd] = exp_wd;
      if (acc) begin
        e.rd   = m_rd;
        e.data = m_data;
        e.kill = 1'b0;
        mq.push_back(e);
      end
      started = 1'b1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("regwrite",   32'(regwrite),   32'(exp_we));
    chk("rd",         32'(rd),         32'(exp_rd));
    chk("writedata",  writedata,       exp_wd);
    chk("m_ready",    32'(m_ready),    32'(started && (mq.size() < DEPTH)));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("busy_rs",    32'(busy_rs),    32'(busy_of(q_rs)));
    chk("busy_rt",    32'(busy_rt),    32'(busy_of(q_rt)));
  end

  task automatic drive(input bit pv, input logic [AW-1:0] prd, input logic [DW-1:0] pd,
                       input bit mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md);
    p_valid = pv;
    p_rd    = prd;
    p_data  = pd;
    m_valid = mv;
    m_rd    = mrd;
    m_data  = md;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;

    // Reset, release off-edge, idle.
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    cyc();
    cyc();
    chk("idle_regwrite", 32'(regwrite),   32'd0);
    chk("idle_m_ready",  32'(m_ready),    32'd1);
    chk("idle_count",    32'(fifo_count), 32'd0);

    // Pipeline write, then an r0 write.
    drive(1, 5'd8, 32'hDEADBEEF, 0, 5'd0, 32'd0);
    cyc();
    chk("p8_regwrite", 32'(regwrite), 32'd1);
    chk("p8_rd",       32'(rd),       32'd8);
    chk("p8_data",     writedata,     32'hDEADBEEF);
    drive(1, 5'd0, 32'h1234, 0, 5'd0, 32'd0);
    cyc();
    chk("p0_regwrite", 32'(regwrite), 32'd0);

    // Fill the queue under a continuous pipeline stream, then drain.
    for (int i = 1; i <= 4; i++) begin
      drive(1, 5'd20, 32'h5000 + 32'(i), 1, 5'(i), 32'(i * 16));
      cyc();
    end
    chk("full_m_ready", 32'(m_ready),    32'd0);
    chk("full_count",   32'(fifo_count), 32'd4);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("drain_regwrite", 32'(regwrite), 32'd1);
      chk("drain_rd",       32'(rd),       32'(i));
      chk("drain_data",     writedata,     32'(i * 16));
      if (i == 1) chk("drain_m_ready", 32'(m_ready), 32'd1);
    end

    // WAW squash of a queued r5 by a younger pipeline write.
    drive(0, 5'd0, 32'd0, 1, 5'd5, 32'hAAAA);
    cyc();
    drive(1, 5'd5, 32'hBBBB, 0, 5'd0, 32'd0);
    cyc();
    chk("waw_p_regwrite", 32'(regwrite), 32'd1);
    chk("waw_p_data",     writedata,     32'hBBBB);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    cyc();
    chk("waw_pop_regwrite", 32'(regwrite),   32'd0);
    chk("waw_pop_count",    32'(fifo_count), 32'd0);
    chk("model_r5",         rf[5],           32'hBBBB);

    // Busy flags around push and pop of r7.
    drive(1, 5'd0, 32'd0, 1, 5'd7, 32'h7777);
    q_rs = 5'd7;
    q_rt = 5'd0;
    #1;
    chk("busy_on_push", 32'(busy_rs), 32'd0);
    cyc();
    drive(1, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    #1;
    chk("busy_rs_q7", 32'(busy_rs), 32'd1);
    chk("busy_rt_q0", 32'(busy_rt), 32'd0);
    cyc();
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    #1;
    chk("busy_while_pop", 32'(busy_rs), 32'd1);
    cyc();
    chk("busy_after_pop", 32'(busy_rs),  32'd0);
    chk("r7_regwrite",    32'(regwrite), 32'd1);
    chk("r7_data",        writedata,     32'h7777);
    q_rs = 5'd0;

    // Same-cycle pipeline and queue writes to r9: queued one is younger.
    drive(1, 5'd9, 32'h99, 1, 5'd9, 32'h9999);
    cyc();
    chk("r9_p_rd",   32'(rd),   32'd9);
    chk("r9_p_data", writedata, 32'h99);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    cyc();
    chk("r9_q_regwrite", 32'(regwrite), 32'd1);
    chk("r9_q_data",     writedata,     32'h9999);

    // Random traffic over a small register range to provoke collisions.
    repeat (3000) begin
      drive($urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)), $urandom);
      q_rs = 5'($urandom_range(0, 7));
      q_rt = 5'($urandom_range(0, 7));
      cyc();
    end
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    q_rs = 5'd0;
    q_rt = 5'd0;
    repeat (6) cyc();

    // Reset with three queued entries and a write in flight.
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd3, 32'h300 + 32'(i), 1, 5'(10 + i), 32'hA0 + 32'(i));
      cyc();
    end
    chk("pre_rst_count",    32'(fifo_count), 32'd3);
    chk("pre_rst_regwrite", 32'(regwrite),   32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_count",    32'(fifo_count), 32'd0);
    chk("rst_regwrite", 32'(regwrite),   32'd0);
    chk("rst_m_ready",  32'(m_ready),    32'd0);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    cyc();
    cyc();
    chk("post_rst_m_ready", 32'(m_ready),    32'd1);
    chk("post_rst_count",   32'(fifo_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
